// File: rtl/exercise_decision.sv
// exercise_decision: LSM early-exercise decision stage. Latches one beta triple per date, then
// streams paths through a 3-stage payoff/continuation pipeline. `DECISION_STATS_EN adds ex_count and checks.
module exercise_decision #(
  parameter int              WIDTH   = 32,
  parameter int              QFRAC   = 16,
  parameter int              N_PATHS = 10000,
  parameter logic [WIDTH-1:0] STRIKE = 32'h0001_0000,
  parameter logic [WIDTH-1:0] DISC   = 32'h0000_FF00,
  parameter int              LANE_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beta_valid,
  output logic                     beta_ready,
  input  logic [WIDTH-1:0]         beta0,
  input  logic [WIDTH-1:0]         beta1,
  input  logic [WIDTH-1:0]         beta2,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [WIDTH-1:0]         s_in,
  input  logic [WIDTH-1:0]         cf_in,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [WIDTH-1:0]         s_out,
  output logic [WIDTH-1:0]         cf_out,
  output logic                     exercised,
  output logic                     date_done,
  output logic [$clog2(N_PATHS):0] ex_count
);

  localparam logic [1:0] WAIT_BETA = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;

  localparam int CW = $clog2(N_PATHS) + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0]           N_LAST   = CW'(N_PATHS);
  localparam logic signed [WIDTH-1:0] STRIKE_S = STRIKE;
  localparam logic signed [WIDTH-1:0] DISC_S   = DISC;
  localparam logic signed [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH+1:0] ext2(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Sums carry two guard bits; clamp back into the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat_sum(input logic signed [WIDTH+1:0] v);
    logic [2:0] top;
    top = v[WIDTH+1:WIDTH-1];
    if (top == 3'b000 || top == 3'b111) sat_sum = v[WIDTH-1:0];
    else if (v[WIDTH+1])                sat_sum = SAT_MIN;
    else                                sat_sum = SAT_MAX;
  endfunction

  function automatic logic signed [WIDTH-1:0] mul_q(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] prod;
    logic [WIDTH:0]       top;
    prod = PW'(a) * PW'(b);
    prod = prod >>> QFRAC;
    top  = prod[PW-1:WIDTH-1];
    if (top == '0 || top == '1) mul_q = prod[WIDTH-1:0];
    else if (prod[PW-1])        mul_q = SAT_MIN;
    else                        mul_q = SAT_MAX;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          beta_ready_q, beta_ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          date_done_q, date_done_d;
  logic signed [WIDTH-1:0] beta0_q, beta0_d, beta1_q, beta1_d, beta2_q, beta2_d;

  logic                    vld_p1_q, vld_p1_d;
  logic signed [WIDTH-1:0] s_p1_q, s_p1_d, cf_p1_q, cf_p1_d, pay_raw_p1_q, pay_raw_p1_d, sq_p1_q, sq_p1_d;
  logic                    vld_p2_q, vld_p2_d;
  logic signed [WIDTH-1:0] s_p2_q, s_p2_d, cf_p2_q, cf_p2_d, pay_p2_q, pay_p2_d;
  logic signed [WIDTH-1:0] m1_p2_q, m1_p2_d, m2_p2_q, m2_p2_d;
  logic                    vld_p3_q, vld_p3_d, ex_p3_q, ex_p3_d;
  logic signed [WIDTH-1:0] s_p3_q, s_p3_d, cf_p3_q, cf_p3_d;

  logic                    adv, acc_in, acc_out, beta_take;
  logic signed [WIDTH-1:0] cont_p3, cf_disc_p3;
  logic                    ex_dec_p3;

  assign adv       = !vld_p3_q || ready_in;
  assign ready_out = (state_q == RUN) && adv;
  assign acc_in    = ready_out && valid_in;
  assign acc_out   = vld_p3_q && ready_in;
  assign beta_take = beta_ready_q && beta_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    date_done_d = 1'b0;
    beta0_d     = beta0_q;
    beta1_d     = beta1_q;
    beta2_d     = beta2_q;
    case (state_q)
      WAIT_BETA: begin
        if (beta_take) begin
          beta0_d = $signed(beta0);
          beta1_d = $signed(beta1);
          beta2_d = $signed(beta2);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (acc_in) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == N_LAST - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The date is finished once the final result leaves with nothing queued behind it.
        if (acc_out && !vld_p1_q && !vld_p2_q) begin
          date_done_d = 1'b1;
          state_d     = WAIT_BETA;
        end
      end
      default: state_d = WAIT_BETA;
    endcase
    beta_ready_d = (state_d == WAIT_BETA);
  end

  always_comb begin
    vld_p1_d     = vld_p1_q;
    s_p1_d       = s_p1_q;
    cf_p1_d      = cf_p1_q;
    pay_raw_p1_d = pay_raw_p1_q;
    sq_p1_d      = sq_p1_q;
    vld_p2_d     = vld_p2_q;
    s_p2_d       = s_p2_q;
    cf_p2_d      = cf_p2_q;
    pay_p2_d     = pay_p2_q;
    m1_p2_d      = m1_p2_q;
    m2_p2_d      = m2_p2_q;
    vld_p3_d     = vld_p3_q;
    s_p3_d       = s_p3_q;
    cf_p3_d      = cf_p3_q;
    ex_p3_d      = ex_p3_q;
    cont_p3      = sat_sum(ext2(beta0_q) + ext2(m1_p2_q) + ext2(m2_p2_q));
    ex_dec_p3    = (pay_p2_q > 0) && (pay_p2_q >= cont_p3);
    cf_disc_p3   = mul_q(cf_p2_q, DISC_S);
    if (adv) begin
      // Stage 1: capture path, raw payoff and S^2
      vld_p1_d     = acc_in;
      s_p1_d       = $signed(s_in);
      cf_p1_d      = $signed(cf_in);
      pay_raw_p1_d = sat_sum(ext2(STRIKE_S) - ext2($signed(s_in)));
      sq_p1_d      = mul_q($signed(s_in), $signed(s_in));
      // Stage 2: regression products and clipped payoff
      vld_p2_d     = vld_p1_q;
      s_p2_d       = s_p1_q;
      cf_p2_d      = cf_p1_q;
      pay_p2_d     = pay_raw_p1_q[WIDTH-1] ? '0 : pay_raw_p1_q;
      m1_p2_d      = mul_q(beta1_q, s_p1_q);
      m2_p2_d      = mul_q(beta2_q, sq_p1_q);
      // Stage 3: continuation, decision and output cashflow
      vld_p3_d     = vld_p2_q;
      if (vld_p2_q) begin
        s_p3_d  = s_p2_q;
        cf_p3_d = ex_dec_p3 ? pay_p2_q : cf_disc_p3;
        ex_p3_d = ex_dec_p3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_BETA;
      beta_ready_q <= 1'b0;
      cnt_q        <= '0;
      date_done_q  <= 1'b0;
      beta0_q      <= '0;
      beta1_q      <= '0;
      beta2_q      <= '0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      s_p3_q       <= '0;
      cf_p3_q      <= '0;
      ex_p3_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beta_ready_q <= beta_ready_d;
      cnt_q        <= cnt_d;
      date_done_q  <= date_done_d;
      beta0_q      <= beta0_d;
      beta1_q      <= beta1_d;
      beta2_q      <= beta2_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      vld_p3_q     <= vld_p3_d;
      s_p3_q       <= s_p3_d;
      cf_p3_q      <= cf_p3_d;
      ex_p3_q      <= ex_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    s_p1_q       <= s_p1_d;
    cf_p1_q      <= cf_p1_d;
    pay_raw_p1_q <= pay_raw_p1_d;
    sq_p1_q      <= sq_p1_d;
    s_p2_q       <= s_p2_d;
    cf_p2_q      <= cf_p2_d;
    pay_p2_q     <= pay_p2_d;
    m1_p2_q      <= m1_p2_d;
    m2_p2_q      <= m2_p2_d;
  end

  assign beta_ready = beta_ready_q;
  assign valid_out  = vld_p3_q;
  assign s_out      = s_p3_q;
  assign cf_out     = cf_p3_q;
  assign exercised  = ex_p3_q;
  assign date_done  = date_done_q;

`ifdef DECISION_STATS_EN
  logic [CW-1:0] ex_cnt_q, ex_cnt_d;

  always_comb begin
    ex_cnt_d = ex_cnt_q;
    if (beta_take) ex_cnt_d = '0;
    else if (acc_out && ex_p3_q && ex_cnt_q != N_LAST) ex_cnt_d = ex_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_cnt_q <= '0;
    else     ex_cnt_q <= ex_cnt_d;
  end

  assign ex_count = ex_cnt_q;

  a_handshake_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(beta_ready && ready_out));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (valid_out && !ready_in) |=> (valid_out && $stable(s_out) && $stable(cf_out) && $stable(exercised)));
`else
  assign ex_count = '0;
`endif

endmodule

// File: tb/tb_exercise_decision.sv
// Randomized self-checking bench for exercise_decision against a plain-arithmetic reference model.
module tb_exercise_decision;
  localparam int NP     = 4;
  localparam int K_V    = 32'h0001_0000;
  localparam int DISC_V = 32'h0000_FF00;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst, beta_valid, beta_ready, valid_in, ready_out, valid_out, ready_in;
  logic [31:0] beta0, beta1, beta2, s_in, cf_in, s_out, cf_out;
  logic        exercised, date_done;
  logic [2:0]  ex_count;

  always #5 clk = ~clk;

  exercise_decision #(.WIDTH(32), .QFRAC(16), .N_PATHS(NP), .STRIKE(32'h0001_0000),
                      .DISC(32'h0000_FF00), .LANE_ID(0)) dut (
    .clk(clk), .rst(rst), .beta_valid(beta_valid), .beta_ready(beta_ready),
    .beta0(beta0), .beta1(beta1), .beta2(beta2), .valid_in(valid_in), .ready_out(ready_out),
    .s_in(s_in), .cf_in(cf_in), .valid_out(valid_out), .ready_in(ready_in), .s_out(s_out),
    .cf_out(cf_out), .exercised(exercised), .date_done(date_done), .ex_count(ex_count));

  int n_tests = 0;
  int n_fail  = 0;
  int in_s[NP+1], in_cf[NP+1];
  int out_s[NP], out_cf[NP], acc_cyc[NP], out_cyc[NP];
  bit out_ex[NP];
  int got, sent, dd_cnt, dd_cyc, hold_bad, both_rdy, extra_acc, extra_out, ro_stall;

  // ---------------- reference model ----------------
  function automatic longint clampw(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic int mulq(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(clampw(p >>> 16));
  endfunction

  task automatic ref_decide(input int b0, input int b1, input int b2, input int s, input int cf,
                            output int cf_o, output bit ex);
    longint pay, cont;
    pay = clampw(longint'(K_V) - longint'(s));
    if (pay < 0) pay = 0;
    cont = clampw(longint'(b0) + longint'(mulq(b1, s)) + longint'(mulq(b2, mulq(s, s))));
    ex   = (pay > 0) && (pay >= cont);
    cf_o = ex ? int'(pay) : mulq(cf, DISC_V);
  endtask

  function automatic int exp_count(input int nex);
`ifdef DECISION_STATS_EN
    return nex;
`else
    return 0 * nex;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_beta(input int b0, input int b1, input int b2);
    int n;
    beta0 = b0; beta1 = b1; beta2 = b2; beta_valid = 1'b1;
    for (n = 0; n < 50 && !beta_ready; n++) @(negedge clk);
    n_tests++;
    if (!beta_ready) begin
      n_fail++;
      $display("FAIL beta_handshake: beta_ready=%0b after %0d cycles, required 1", beta_ready, n);
    end
    @(negedge clk);
    beta_valid = 1'b0;
  endtask

  task automatic run_date(input int b0, input int b1, input int b2,
                          input int stall_at, input int stall_len, input bit gaps);
    bit   stalled_prev, acc, oacc;
    logic [31:0] ps, pc;
    logic pe;
    sent = 0; got = 0; dd_cnt = 0; dd_cyc = -1; hold_bad = 0; both_rdy = 0;
    extra_acc = 0; extra_out = 0; ro_stall = 0;
    do_beta(b0, b1, b2);
    stalled_prev = 0; ps = '0; pc = '0; pe = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      ready_in = !(cyc >= stall_at && cyc < stall_at + stall_len);
      valid_in = (sent >= NP) ? 1'b1 : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      s_in     = in_s[(sent < NP) ? sent : NP];
      cf_in    = in_cf[(sent < NP) ? sent : NP];
      #1;
      if (beta_ready && ready_out) both_rdy++;
      if (valid_out && !ready_in && ready_out) ro_stall++;
      if (stalled_prev && !(valid_out && s_out == ps && cf_out == pc && exercised == pe)) hold_bad++;
      stalled_prev = valid_out && !ready_in;
      ps = s_out; pc = cf_out; pe = exercised;
      if (date_done) begin dd_cnt++; dd_cyc = cyc; end
      acc  = valid_in && ready_out;
      oacc = valid_out && ready_in;
      if (oacc) begin
        if (got < NP) begin
          out_s[got] = s_out; out_cf[got] = cf_out; out_ex[got] = exercised;
          out_cyc[got] = cyc; got++;
        end else extra_out++;
      end
      if (acc) begin
        if (sent < NP) begin acc_cyc[sent] = cyc; sent++; end
        else extra_acc++;
      end
      if (got == NP && cyc >= out_cyc[NP-1] + 4) break;
      @(negedge clk);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
  endtask

  task automatic rand_paths();
    for (int i = 0; i <= NP; i++) begin
      in_s[i]  = int'($urandom_range(32'h4000, 32'h18000));
      in_cf[i] = int'($urandom_range(0, 32'h10000));
    end
  endtask

  function automatic int rnd_q(input int half);
    return int'($urandom_range(0, 2 * half)) - half;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; beta_valid = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    beta0 = '0; beta1 = '0; beta2 = '0; s_in = '0; cf_in = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (beta_ready !== 1'b0) begin n_fail++; $display("FAIL rst_beta_ready: got %0b want 0", beta_ready); end
    n_tests++; if (ready_out !== 1'b0)  begin n_fail++; $display("FAIL rst_ready_out: got %0b want 0", ready_out); end
    n_tests++; if (valid_out !== 1'b0)  begin n_fail++; $display("FAIL rst_valid_out: got %0b want 0", valid_out); end
    n_tests++; if (date_done !== 1'b0)  begin n_fail++; $display("FAIL rst_date_done: got %0b want 0", date_done); end
    n_tests++; if (exercised !== 1'b0)  begin n_fail++; $display("FAIL rst_exercised: got %0b want 0", exercised); end
    n_tests++; if (s_out !== 32'h0)     begin n_fail++; $display("FAIL rst_s_out: got %h want 0", s_out); end
    n_tests++; if (cf_out !== 32'h0)    begin n_fail++; $display("FAIL rst_cf_out: got %h want 0", cf_out); end
    n_tests++; if (ex_count !== 3'd0)   begin n_fail++; $display("FAIL rst_ex_count: got %0d want 0", ex_count); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (beta_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_beta_ready: got %0b want 1", beta_ready); end
    n_tests++; if (ready_out !== 1'b0)  begin n_fail++; $display("FAIL post_rst_ready_out: got %0b want 0", ready_out); end
  endtask

  task automatic test_itm_exercise();
    int ecf, nex; bit eex;
    rand_paths();
    in_s[0] = 32'h0000_E666; in_cf[0] = 32'h0000_8000;
    run_date(32'h0CCD, 0, 0, 1000, 0, 1'b0);
    nex = 0;
    for (int i = 0; i < NP; i++) begin
      ref_decide(32'h0CCD, 0, 0, in_s[i], in_cf[i], ecf, eex);
      nex += int'(eex);
      n_tests++;
      if (got <= i || out_s[i] !== in_s[i] || out_cf[i] !== ecf || out_ex[i] !== eex) begin
        n_fail++;
        $display("FAIL itm_path%0d: got s=%h cf=%h ex=%0b want s=%h cf=%h ex=%0b", i, out_s[i], out_cf[i], out_ex[i], in_s[i], ecf, eex);
      end
    end
    n_tests++; if (out_cf[0] !== 32'h0000_199A || out_ex[0] !== 1'b1) begin n_fail++; $display("FAIL itm_const: got cf=%h ex=%0b want 0000199a/1", out_cf[0], out_ex[0]); end
    n_tests++; if (out_cyc[0] - acc_cyc[0] !== 3) begin n_fail++; $display("FAIL latency: got %0d want 3", out_cyc[0] - acc_cyc[0]); end
    n_tests++; if (out_cyc[NP-1] - out_cyc[0] !== NP - 1) begin n_fail++; $display("FAIL out_consecutive: got span %0d want %0d", out_cyc[NP-1] - out_cyc[0], NP - 1); end
    n_tests++; if (dd_cnt !== 1 || dd_cyc !== out_cyc[NP-1] + 1) begin n_fail++; $display("FAIL date_done: got count=%0d cyc=%0d want 1 at %0d", dd_cnt, dd_cyc, out_cyc[NP-1] + 1); end
    n_tests++; if (extra_acc !== 0 || extra_out !== 0) begin n_fail++; $display("FAIL fifth_sample: got extra acc=%0d out=%0d want 0/0", extra_acc, extra_out); end
    n_tests++; if (both_rdy !== 0) begin n_fail++; $display("FAIL ready_overlap: got %0d cycles want 0", both_rdy); end
    n_tests++; if (int'(ex_count) !== exp_count(nex)) begin n_fail++; $display("FAIL itm_ex_count: got %0d want %0d", ex_count, exp_count(nex)); end
  endtask

  task automatic test_decision_rules();
    int bt[4][3] = '{'{32'h3333, 0, 0}, '{-65536, 0, 0}, '{32'h199A, 0, 0},
                     '{32'h7FFF_FFFF, 32'h7FFF_0000, 32'h7FFF_0000}};
    int st[4][4] = '{'{32'h0000_E666, 32'h0000_C000, 32'h0001_4000, 32'h0001_0000},
                     '{32'h0001_199A, 32'h0001_0000, 32'h0000_8000, 32'h0000_E666},
                     '{32'h0000_E666, 32'h0000_F000, 32'h0000_D000, 32'h0001_2000},
                     '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0001_0000}};
    int ecf, nex; bit eex;
    for (int d = 0; d < 4; d++) begin
      rand_paths();
      for (int i = 0; i < NP; i++) in_s[i] = st[d][i];
      in_cf[0] = 32'h0000_4CCD;
      run_date(bt[d][0], bt[d][1], bt[d][2], 1000, 0, 1'b0);
      nex = 0;
      for (int i = 0; i < NP; i++) begin
        ref_decide(bt[d][0], bt[d][1], bt[d][2], in_s[i], in_cf[i], ecf, eex);
        nex += int'(eex);
        n_tests++;
        if (got <= i || out_s[i] !== in_s[i] || out_cf[i] !== ecf || out_ex[i] !== eex) begin
          n_fail++;
          $display("FAIL rules_d%0d_p%0d: got s=%h cf=%h ex=%0b want s=%h cf=%h ex=%0b", d, i, out_s[i], out_cf[i], out_ex[i], in_s[i], ecf, eex);
        end
      end
      n_tests++; if (int'(ex_count) !== exp_count(nex)) begin n_fail++; $display("FAIL rules_d%0d_ex_count: got %0d want %0d", d, ex_count, exp_count(nex)); end
      case (d)
        0: begin n_tests++; if (out_ex[0] !== 1'b0 || out_cf[0] !== 32'h0000_4C80) begin n_fail++; $display("FAIL cont_wins: got ex=%0b cf=%h want 0/00004c80", out_ex[0], out_cf[0]); end end
        1: begin n_tests++; if ({out_ex[0], out_ex[1], out_ex[2], out_ex[3]} !== 4'b0011) begin n_fail++; $display("FAIL otm_negcont: got ex=%0b%0b%0b%0b want 0011", out_ex[0], out_ex[1], out_ex[2], out_ex[3]); end end
        2: begin n_tests++; if (out_ex[0] !== 1'b1 || out_cf[0] !== 32'h0000_199A) begin n_fail++; $display("FAIL tie_exercise: got ex=%0b cf=%h want 1/0000199a", out_ex[0], out_cf[0]); end end
        default: begin n_tests++; if (out_ex[0] !== 1'b1 || out_cf[0] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL saturate: got ex=%0b cf=%h want 1/7fffffff", out_ex[0], out_cf[0]); end end
      endcase
    end
  endtask

  task automatic test_back_to_back(input int dates, input bit gaps);
    int b0, b1, b2, ecf, nex; bit eex;
    for (int d = 0; d < dates; d++) begin
      rand_paths();
      b0 = rnd_q(32'h8000); b1 = rnd_q(32'h10000); b2 = rnd_q(32'h8000);
      run_date(b0, b1, b2, 1000, 0, gaps);
      nex = 0;
      for (int i = 0; i < NP; i++) begin
        ref_decide(b0, b1, b2, in_s[i], in_cf[i], ecf, eex);
        nex += int'(eex);
        n_tests++;
        if (got <= i || out_s[i] !== in_s[i] || out_cf[i] !== ecf || out_ex[i] !== eex) begin
          n_fail++;
          $display("FAIL b2b_g%0b_d%0d_p%0d: got s=%h cf=%h ex=%0b want s=%h cf=%h ex=%0b", gaps, d, i, out_s[i], out_cf[i], out_ex[i], in_s[i], ecf, eex);
        end
      end
      n_tests++; if (dd_cnt !== 1 || extra_out !== 0) begin n_fail++; $display("FAIL b2b_done_d%0d: got date_done=%0d extra=%0d want 1/0", d, dd_cnt, extra_out); end
      n_tests++; if (int'(ex_count) !== exp_count(nex)) begin n_fail++; $display("FAIL b2b_ex_count_d%0d: got %0d want %0d", d, ex_count, exp_count(nex)); end
    end
  endtask

  task automatic test_stall(input int at, input int len);
    int b0, b1, b2, ecf; bit eex;
    rand_paths();
    b0 = rnd_q(32'h8000); b1 = rnd_q(32'h10000); b2 = rnd_q(32'h8000);
    run_date(b0, b1, b2, at, len, 1'b0);
    for (int i = 0; i < NP; i++) begin
      ref_decide(b0, b1, b2, in_s[i], in_cf[i], ecf, eex);
      n_tests++;
      if (got <= i || out_s[i] !== in_s[i] || out_cf[i] !== ecf || out_ex[i] !== eex) begin
        n_fail++;
        $display("FAIL stall%0d_p%0d: got s=%h cf=%h ex=%0b want s=%h cf=%h ex=%0b", at, i, out_s[i], out_cf[i], out_ex[i], in_s[i], ecf, eex);
      end
    end
    n_tests++; if (hold_bad !== 0) begin n_fail++; $display("FAIL stall%0d_hold: got %0d unstable cycles want 0", at, hold_bad); end
    n_tests++; if (ro_stall !== 0) begin n_fail++; $display("FAIL stall%0d_ready_out: got %0d cycles high want 0", at, ro_stall); end
    n_tests++; if (dd_cnt !== 1 || extra_out !== 0 || extra_acc !== 0) begin n_fail++; $display("FAIL stall%0d_done: got dd=%0d xo=%0d xa=%0d want 1/0/0", at, dd_cnt, extra_out, extra_acc); end
  endtask

  task automatic test_reset_midrun();
    int vo_seen, dd_seen;
    rand_paths();
    do_beta(32'h0CCD, 0, 0);
    ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; s_in = 32'h0000_E666; cf_in = in_cf[i];
      @(negedge clk);
    end
    valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_out: got %0b want 0", valid_out); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (beta_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_beta_ready: got %0b want 1", beta_ready); end
    n_tests++; if (ex_count !== 3'd0)   begin n_fail++; $display("FAIL midrst_ex_count: got %0d want 0", ex_count); end
    vo_seen = 0; dd_seen = 0;
    repeat (5) begin
      if (valid_out) vo_seen++;
      if (date_done) dd_seen++;
      @(negedge clk);
    end
    n_tests++; if (vo_seen !== 0 || dd_seen !== 0) begin n_fail++; $display("FAIL midrst_quiet: got valid=%0d done=%0d want 0/0", vo_seen, dd_seen); end
    test_back_to_back(1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_itm_exercise();
    test_decision_rules();
    test_back_to_back(3, 1'b0);
    test_back_to_back(3, 1'b1);
    test_stall(2, 5);
    test_stall(3, 4);
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
